mem_wb_stage_nlane: RTL
=======================

// Module: mem_wb_stage_nlane
// PURPOSE
//  Parametrised N-lane MEM->WB pipeline register for the dual-issue core, successor to the single-lane MEM/WB latch.
//  Adds per-lane valid, stall (hold) and flush (bubble), and a writeback-data select done before the register.
//  Also adds a same-cycle write-after-write resolution between lanes, so the register file sees at most one writer per address.
//  Sits between the data-memory stage and the register-file write ports. Lane 0 is always the older instruction.
// PARAMETERS
//  LANES   2   issue lanes; lane i uses slice [i*W +: W] of every packed bus
//  DATA_W  32  datapath width
//  REG_AW  5   register address width; register 0 is hard-wired zero
//  PC_W    6   width of the pcPlus1 field; zero-extended to DATA_W on link writes
//  CNT_W   32  retire-counter width (only with MEM_WB_PERF_CNT_EN)
// PORTS
//  clk                 in   1              rising-edge clock
//  reset               in   1              synchronous, active-low reset
//  stall               in   1              hold every WB register (stall has lower priority than flush)
//  flush               in   1              next cycle becomes a bubble on all lanes
//  valid_m             in   LANES          lane carries a real instruction in MEM
//  memoryReadDataMem   in   LANES*DATA_W   load data per lane
//  AluResultMem        in   LANES*DATA_W   ALU result per lane
//  pcPlus1Mem          in   LANES*PC_W     return address per lane
//  rd_or_rt_M          in   LANES*REG_AW   resolved destination per lane
//  MemtoRegMem         in   LANES*2        00 ALU, 01 mem, 10 link (pcPlus1), 11 ALU (reserved)
//  RegWriteMem         in   LANES          lane writes the register file
//  valid_wb            out  LANES          registered lane valid
//  wb_we               out  LANES          final register-file write enable per lane
//  wb_addr             out  LANES*REG_AW   final write address per lane
//  wb_data             out  LANES*DATA_W   final write data per lane
//  retired_cnt         out  CNT_W          retired instruction count (only with MEM_WB_PERF_CNT_EN)
// BEHAVIOUR
//  - Priority at each rising edge of clk: reset==0 > flush > stall > capture. All registers update only on that edge.
//  - Reset: valid_wb, wb_we, wb_addr, wb_data and retired_cnt are all 0 on the first edge with reset low.
//  - Reset low mid-stall or mid-flush still clears every register; the inputs are ignored on that edge.
//  - Flush: valid_wb=0, wb_we=0, wb_addr=0, wb_data=0 on all lanes. This holds even if stall=1 in the same cycle.
//  - Stall (flush=0): every output holds its value. Holding is not a new retirement, so the counter does not increment.
//  - Capture: latency is 1 cycle, from the MEM inputs to the WB outputs. Computed combinationally from the inputs, then registered.
//  - Per-lane data select:
//      MemtoReg=01 -> memoryReadData
//      MemtoReg=10 -> {zeros, pcPlus1}
//      MemtoReg=00 or 11 -> AluResult
//  - Per-lane address: MemtoReg=10 forces wb_addr=31 (link register). Otherwise wb_addr=rd_or_rt.
//  - Per-lane enable: we_i = valid_m[i] & RegWriteMem[i] & (addr_i != 0).
//  - Write-after-write resolution: if a younger lane j>i has we_j=1 and addr_j==addr_i, then we_i is forced to 0. The younger write wins.
//  - Suppressed lanes keep valid_wb=1 and their data; only wb_we is cleared.
//  - valid_m[i]=0 on capture: valid_wb[i]=0 and wb_we[i]=0. wb_addr and wb_data still capture, but are don't-care.
// CONFIGURATION
//  MEM_WB_PERF_CNT_EN defined:
//  - retired_cnt adds popcount(valid_m) on every capture edge (no reset, no flush, no stall).
//  - The counter wraps modulo 2^CNT_W. It is cleared only by reset.
//  MEM_WB_PERF_CNT_EN undefined:
//  - The retired_cnt port and the counter logic are absent.
// TESTING
//  - Reset: hold reset=0 for 2 edges with random inputs -> every output is 0. Release reset -> outputs follow the inputs one edge later.
//  - Select and link, two lanes:
//      lane0 MemtoReg=01, mem=0xDEADBEEF, rd=5 -> wb_data0=0xDEADBEEF, wb_addr0=5, we0=1
//      lane1 MemtoReg=10, pc=0x2A -> wb_data1=0x0000002A, wb_addr1=31, we1=1
//  - Write-after-write: both lanes valid and writing rd=7, alu0=1, alu1=2 -> we0=0, we1=1, wb_data1=2, valid_wb=2'b11.
//    Repeat with rd=0 on both lanes -> we=2'b00.
//  - Stall then flush: capture A, then stall=1 for 3 cycles with new inputs -> outputs stay A.
//    Then stall=1 and flush=1 together -> valid_wb=0, wb_we=0, wb_data=0.
//  - Counter (with MEM_WB_PERF_CNT_EN): 4 captures of valid_m=11, 1 stall, 1 flush, 2 captures of valid_m=01 -> retired_cnt=10.
//    Preload to 2^CNT_W-1, then one capture of valid_m=11 -> wraps to 1.

Source files
------------

// File: rtl/mem_wb_stage_nlane.sv
// mem_wb_stage_nlane
// N-lane MEM->WB pipeline register. It selects the writeback data before the
// register, resolves same-cycle write-after-write conflicts between lanes so
// that the younger lane wins, and supports per-stage stall and flush.
// Lane 0 is always the older instruction.
// Optional feature macro: MEM_WB_PERF_CNT_EN adds the retired_cnt counter.
module mem_wb_stage_nlane #(
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int PC_W   = 6,
   parameter int CNT_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [LANES-1:0]          valid_m,
   input  logic [LANES*DATA_W-1:0]   memoryReadDataMem,
   input  logic [LANES*DATA_W-1:0]   AluResultMem,
   input  logic [LANES*PC_W-1:0]     pcPlus1Mem,
   input  logic [LANES*REG_AW-1:0]   rd_or_rt_M,
   input  logic [LANES*2-1:0]        MemtoRegMem,
   input  logic [LANES-1:0]          RegWriteMem,
   output logic [LANES-1:0]          valid_wb,
   output logic [LANES-1:0]          wb_we,
   output logic [LANES*REG_AW-1:0]   wb_addr,
`ifdef MEM_WB_PERF_CNT_EN
   output logic [LANES*DATA_W-1:0]   wb_data,
   output logic [CNT_W-1:0]          retired_cnt
`else
   output logic [LANES*DATA_W-1:0]   wb_data
`endif
);

   localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);

   logic [LANES*DATA_W-1:0] sel_data;
   logic [LANES*REG_AW-1:0] sel_addr;
   logic [LANES-1:0]        we_raw;
   logic [LANES-1:0]        we_fin;

   logic [LANES-1:0]        valid_wb_q, valid_wb_d;
   logic [LANES-1:0]        wb_we_q,    wb_we_d;
   logic [LANES*REG_AW-1:0] wb_addr_q,  wb_addr_d;
   logic [LANES*DATA_W-1:0] wb_data_q,  wb_data_d;

   // Per-lane writeback data/address select and raw write enable
   always_comb begin
      // NOTE: every output of a comb block gets a default first so no latch is inferred.
      sel_data = '0;
      sel_addr = '0;
      we_raw   = '0;
      for (int i = 0; i < LANES; i++) begin
         case (MemtoRegMem[i*2 +: 2])
            2'b01:   sel_data[i*DATA_W +: DATA_W] = memoryReadDataMem[i*DATA_W +: DATA_W];
            2'b10:   sel_data[i*DATA_W +: DATA_W] = DATA_W'(pcPlus1Mem[i*PC_W +: PC_W]);
            default: sel_data[i*DATA_W +: DATA_W] = AluResultMem[i*DATA_W +: DATA_W];
         endcase
         sel_addr[i*REG_AW +: REG_AW] = (MemtoRegMem[i*2 +: 2] == 2'b10) ? LINK_REG
                                                                         : rd_or_rt_M[i*REG_AW +: REG_AW];
         we_raw[i] = valid_m[i] & RegWriteMem[i] & (sel_addr[i*REG_AW +: REG_AW] != '0);
      end
   end

   // Write-after-write resolution: an older lane loses to any younger writer of the same address
   always_comb begin
      we_fin = we_raw;
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (we_raw[j] && (sel_addr[j*REG_AW +: REG_AW] == sel_addr[i*REG_AW +: REG_AW])) begin
               we_fin[i] = 1'b0;
            end
         end
      end
   end

   // Next-state of the WB register: flush beats stall beats capture
   always_comb begin
      valid_wb_d = valid_wb_q;
      wb_we_d    = wb_we_q;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      if (flush) begin
         valid_wb_d = '0;
         wb_we_d    = '0;
         wb_addr_d  = '0;
         wb_data_d  = '0;
      end else if (!stall) begin
         valid_wb_d = valid_m;
         wb_we_d    = we_fin;
         wb_addr_d  = sel_addr;
         wb_data_d  = sel_data;
      end
   end

   // WB register with synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!reset) begin
         valid_wb_q <= '0;
         wb_we_q    <= '0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         valid_wb_q <= valid_wb_d;
         wb_we_q    <= wb_we_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign valid_wb = valid_wb_q;
   assign wb_we    = wb_we_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;

`ifdef MEM_WB_PERF_CNT_EN
   logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
   logic [CNT_W-1:0] valid_pop;

   // Retire counter: adds the number of valid lanes on each capture edge, wraps naturally
   always_comb begin
      valid_pop = '0;
      for (int i = 0; i < LANES; i++) begin
         valid_pop = valid_pop + CNT_W'(valid_m[i]);
      end
      retired_cnt_d = retired_cnt_q;
      if (!flush && !stall) begin
         retired_cnt_d = retired_cnt_q + valid_pop;
      end
   end

   // Counter register, cleared only by reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         retired_cnt_q <= '0;
      end else begin
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign retired_cnt = retired_cnt_q;
`endif

endmodule
